// File: rtl/aggr_feedback.sv
`default_nettype none
// ============================================================================
// Module   : aggr_feedback
// Brief    : Return path of the scanline cost aggregator: pipelined argmin over
//            the aggregated cost vector, feedback hold and WTA disparity out.
// Revision : 1.0 - initial release
// ============================================================================
module aggr_feedback #(
    parameter int DISP_RANGE    = 108,
    parameter int PIXEL_WIDTH   = 8,
    parameter int MIN_DISPARITY = 20,
    parameter int FRAME_WIDTH   = 400
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [9:0]                        in_row,
    input  logic [9:0]                        in_col,
    input  logic [DISP_RANGE*PIXEL_WIDTH-1:0] in_cost,
    output logic [DISP_RANGE*PIXEL_WIDTH-1:0] cost_aggr_last,
    output logic [PIXEL_WIDTH-1:0]            min_aggr_last,
    output logic                              fb_ready,
    output logic [9:0]                        fb_row,
    output logic [9:0]                        fb_col,
    output logic                              disp_valid,
    output logic [7:0]                        disp_out,
    output logic [9:0]                        disp_row,
    output logic [9:0]                        disp_col,
    output logic                              err_order
);

    localparam int c_vec_w = DISP_RANGE * PIXEL_WIDTH;
    localparam int c_idx_w = 7;
    localparam int c_n1    = (DISP_RANGE + 1) / 2;
    localparam int c_n2    = (c_n1 + 1) / 2;
    localparam int c_n3    = (c_n2 + 1) / 2;
    localparam int c_n4    = (c_n3 + 1) / 2;
    localparam int c_n5    = (c_n4 + 1) / 2;
    localparam int c_n6    = (c_n5 + 1) / 2;

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] val;
        logic [c_idx_w-1:0]     idx;
    } node_t;

    // All-ones padding loses every compare against a real entry.
    localparam node_t c_pad = '1;

    function automatic node_t pick(input node_t a, input node_t b);
        return (b.val < a.val) ? b : a;
    endfunction

    // ---------------- pipeline registers ----------------
    logic [c_vec_w-1:0] cost_c_d,  cost_c_q,  cost_t1_d, cost_t1_q;
    logic [c_vec_w-1:0] cost_t2_d, cost_t2_q, cost_t3_d, cost_t3_q;
    logic [c_vec_w-1:0] cost_t4_d, cost_t4_q;
    logic [9:0] row_c_d,  row_c_q,  col_c_d,  col_c_q;
    logic [9:0] row_t1_d, row_t1_q, col_t1_d, col_t1_q;
    logic [9:0] row_t2_d, row_t2_q, col_t2_d, col_t2_q;
    logic [9:0] row_t3_d, row_t3_q, col_t3_d, col_t3_q;
    logic [9:0] row_t4_d, row_t4_q, col_t4_d, col_t4_q;
    logic vld_c_d, vld_c_q, vld_t1_d, vld_t1_q, vld_t2_d, vld_t2_q;
    logic vld_t3_d, vld_t3_q, vld_t4_d, vld_t4_q;

    node_t t1_d [c_n2];
    node_t t1_q [c_n2];
    node_t t2_d [c_n4];
    node_t t2_q [c_n4];
    node_t t3_d [c_n6];
    node_t t3_q [c_n6];
    node_t t4_d, t4_q;

    // Level arrays are sized even so every pair exists; unused slots hold padding.
    node_t lv0 [2*c_n1];
    node_t lv1 [2*c_n2];
    node_t lv2 [2*c_n3];
    node_t lv3 [2*c_n4];
    node_t lv4 [2*c_n5];
    node_t lv5 [2*c_n6];
    node_t lv6 [2];

    always_comb begin
        for (int k = 0; k < 2*c_n1; k++) lv0[k] = c_pad;
        for (int k = 0; k < DISP_RANGE; k++)
            lv0[k] = {cost_c_q[k*PIXEL_WIDTH +: PIXEL_WIDTH], c_idx_w'(k)};
        for (int k = 0; k < 2*c_n2; k++) lv1[k] = c_pad;
        for (int k = 0; k < c_n1; k++) lv1[k] = pick(lv0[2*k], lv0[2*k+1]);
        for (int k = 0; k < c_n2; k++) t1_d[k] = pick(lv1[2*k], lv1[2*k+1]);

        for (int k = 0; k < 2*c_n3; k++) lv2[k] = c_pad;
        for (int k = 0; k < c_n2; k++) lv2[k] = t1_q[k];
        for (int k = 0; k < 2*c_n4; k++) lv3[k] = c_pad;
        for (int k = 0; k < c_n3; k++) lv3[k] = pick(lv2[2*k], lv2[2*k+1]);
        for (int k = 0; k < c_n4; k++) t2_d[k] = pick(lv3[2*k], lv3[2*k+1]);

        for (int k = 0; k < 2*c_n5; k++) lv4[k] = c_pad;
        for (int k = 0; k < c_n4; k++) lv4[k] = t2_q[k];
        for (int k = 0; k < 2*c_n6; k++) lv5[k] = c_pad;
        for (int k = 0; k < c_n5; k++) lv5[k] = pick(lv4[2*k], lv4[2*k+1]);
        for (int k = 0; k < c_n6; k++) t3_d[k] = pick(lv5[2*k], lv5[2*k+1]);

        for (int k = 0; k < 2; k++) lv6[k] = c_pad;
        for (int k = 0; k < c_n6; k++) lv6[k] = t3_q[k];
        t4_d = pick(lv6[0], lv6[1]);
    end

    // Vector, coordinates and valid bit move in lockstep with the min tree.
    always_comb begin
        cost_c_d  = in_cost;   row_c_d  = in_row;   col_c_d  = in_col;   vld_c_d  = in_valid;
        cost_t1_d = cost_c_q;  row_t1_d = row_c_q;  col_t1_d = col_c_q;  vld_t1_d = vld_c_q;
        cost_t2_d = cost_t1_q; row_t2_d = row_t1_q; col_t2_d = col_t1_q; vld_t2_d = vld_t1_q;
        cost_t3_d = cost_t2_q; row_t3_d = row_t2_q; col_t3_d = col_t2_q; vld_t3_d = vld_t2_q;
        cost_t4_d = cost_t3_q; row_t4_d = row_t3_q; col_t4_d = col_t3_q; vld_t4_d = vld_t3_q;
    end

    always_ff @(posedge clk) begin
        cost_c_q  <= cost_c_d;  row_c_q  <= row_c_d;  col_c_q  <= col_c_d;
        cost_t1_q <= cost_t1_d; row_t1_q <= row_t1_d; col_t1_q <= col_t1_d;
        cost_t2_q <= cost_t2_d; row_t2_q <= row_t2_d; col_t2_q <= col_t2_d;
        cost_t3_q <= cost_t3_d; row_t3_q <= row_t3_d; col_t3_q <= col_t3_d;
        cost_t4_q <= cost_t4_d; row_t4_q <= row_t4_d; col_t4_q <= col_t4_d;
        t1_q      <= t1_d;
        t2_q      <= t2_d;
        t3_q      <= t3_d;
        t4_q      <= t4_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_c_q  <= 1'b0;
            vld_t1_q <= 1'b0;
            vld_t2_q <= 1'b0;
            vld_t3_q <= 1'b0;
            vld_t4_q <= 1'b0;
        end else begin
            vld_c_q  <= vld_c_d;
            vld_t1_q <= vld_t1_d;
            vld_t2_q <= vld_t2_d;
            vld_t3_q <= vld_t3_d;
            vld_t4_q <= vld_t4_d;
        end
    end

    // ---------------- output stage, in-flight count, order check ----------------
    logic [c_vec_w-1:0]     cost_last_d, cost_last_q;
    logic [PIXEL_WIDTH-1:0] min_last_d, min_last_q;
    logic [9:0]             fb_row_d, fb_row_q, fb_col_d, fb_col_q;
    logic [9:0]             disp_row_d, disp_row_q, disp_col_d, disp_col_q;
    logic [7:0]             disp_out_d, disp_out_q;
    logic                   disp_valid_d, disp_valid_q;
    logic [2:0]             cnt_d, cnt_q;
    logic [9:0]             prev_row_d, prev_row_q, prev_col_d, prev_col_q;
    logic                   have_prev_d, have_prev_q;
    logic                   err_d, err_q;
    logic                   w_order_ok;

    always_comb begin
        cost_last_d  = cost_last_q;
        min_last_d   = min_last_q;
        fb_row_d     = fb_row_q;
        fb_col_d     = fb_col_q;
        disp_row_d   = disp_row_q;
        disp_col_d   = disp_col_q;
        disp_out_d   = disp_out_q;
        disp_valid_d = 1'b0;
        if (vld_t4_q) begin
            cost_last_d  = cost_t4_q;
            min_last_d   = t4_q.val;
            fb_row_d     = row_t4_q;
            fb_col_d     = col_t4_q;
            disp_row_d   = row_t4_q;
            disp_col_d   = col_t4_q;
            disp_out_d   = 8'(t4_q.idx) + 8'(MIN_DISPARITY);
            disp_valid_d = 1'b1;
        end

        cnt_d = cnt_q;
        case ({in_valid, vld_t4_q})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase

        // A row may only start at col 0 or continue with the next column.
        w_order_ok = (in_col == 10'd0) ||
                     (have_prev_q && (in_row == prev_row_q) &&
                      (in_col == prev_col_q + 10'd1) &&
                      (prev_col_q < 10'(FRAME_WIDTH - 1)));

        prev_row_d  = prev_row_q;
        prev_col_d  = prev_col_q;
        have_prev_d = have_prev_q;
        err_d       = err_q;
        if (in_valid) begin
            prev_row_d  = in_row;
            prev_col_d  = in_col;
            have_prev_d = 1'b1;
            err_d       = err_q | ~w_order_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cost_last_q  <= '1;
            min_last_q   <= '1;
            fb_row_q     <= '0;
            fb_col_q     <= '0;
            disp_row_q   <= '0;
            disp_col_q   <= '0;
            disp_out_q   <= '0;
            disp_valid_q <= 1'b0;
            cnt_q        <= 3'd0;
            prev_row_q   <= '0;
            prev_col_q   <= '0;
            have_prev_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cost_last_q  <= cost_last_d;
            min_last_q   <= min_last_d;
            fb_row_q     <= fb_row_d;
            fb_col_q     <= fb_col_d;
            disp_row_q   <= disp_row_d;
            disp_col_q   <= disp_col_d;
            disp_out_q   <= disp_out_d;
            disp_valid_q <= disp_valid_d;
            cnt_q        <= cnt_d;
            prev_row_q   <= prev_row_d;
            prev_col_q   <= prev_col_d;
            have_prev_q  <= have_prev_d;
            err_q        <= err_d;
        end
    end

    assign cost_aggr_last = cost_last_q;
    assign min_aggr_last  = min_last_q;
    assign fb_row         = fb_row_q;
    assign fb_col         = fb_col_q;
    assign fb_ready       = (cnt_q == 3'd0);
    assign disp_valid     = disp_valid_q;
    assign disp_out       = disp_out_q;
    assign disp_row       = disp_row_q;
    assign disp_col       = disp_col_q;
    assign err_order      = err_q;

endmodule
`default_nettype wire

// File: doc/aggr_feedback.md
# aggr_feedback

Return-path block for the scanline cost aggregator. It takes the aggregator's per-pixel output (aggregated cost vector, row, col, valid) and finds its minimum over all disparities with a pipelined reduction. It holds that vector and minimum as the `cost_aggr_last` / `min_aggr_last` feedback for the next pixel on the row, and emits a winner-take-all disparity stream. It also tells the pixel issuer when the feedback for the newest pixel is ready, and flags out-of-order input.

## Interface
- `DISP_RANGE`, default 108: disparities per vector.
- `PIXEL_WIDTH`, default 8: bits per cost.
- `MIN_DISPARITY`, default 20: offset added to the argmin index.
- `FRAME_WIDTH`, default 400: pixels per row; the last column is `FRAME_WIDTH-1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  aggregator `valid`.
- `in_row`  in  10  aggregator `out_row`.
- `in_col`  in  10  aggregator `out_col`.
- `in_cost`  in  `DISP_RANGE*PIXEL_WIDTH` (864)  aggregator `cost_aggr`; disparity d occupies bits `[8d+7:8d]`.
- `cost_aggr_last`  out  864  most recent vector, fed back to the aggregator.
- `min_aggr_last`  out  8  minimum of `cost_aggr_last`.
- `fb_ready`  out  1  high when no pixel is in flight, so the feedback is current.
- `fb_row`, `fb_col`  out  10 each  pixel that `cost_aggr_last` belongs to.
- `disp_valid`  out  1  one-cycle strobe per pixel.
- `disp_out`  out  8  argmin index + `MIN_DISPARITY`.
- `disp_row`, `disp_col`  out  10 each  pixel coordinates for `disp_out`.
- `err_order`  out  1  sticky input-order error.

## Operation
- Stage C (capture): on `in_valid`, register `in_cost`, `in_row`, `in_col` and a valid bit. Data is registered even when `in_valid` is low, but only valid-tagged data updates the outputs.
- Min tree: unsigned 8-bit compare; each node carries a value and a 7-bit index. On a tie the lower index wins.
  - T1: 108 → 54 → 27.
  - T2: 27 → 14 → 7. Odd leftover entries pass through; padding is value 0xFF with index 127, which never beats a real entry.
  - T3: 7 → 4 → 2.
  - T4: 2 → 1.
  - The vector, row, col and valid bit travel in lockstep through T1–T4.
- Output stage O, when the T4 valid bit is set:
  - `cost_aggr_last` ← vector; `min_aggr_last` ← min; `fb_row` / `fb_col` ← coordinates.
  - `disp_out` ← index + `MIN_DISPARITY` as an 8-bit sum; the maximum is 107 + 20 = 127, so it cannot overflow.
  - `disp_row` / `disp_col` ← coordinates; `disp_valid` ← 1.
  - Otherwise `disp_valid` ← 0 and all other outputs hold.
- In-flight counter (3 bits, range 0–5):
  - +1 when `in_valid` is sampled; −1 when stage O fires; simultaneous +1/−1 leaves it unchanged.
  - `fb_ready` = (count == 0), decoded from the registered count.
- Order checker: keep the last accepted (row, col). An accepted pixel is legal if either:
  - same row and col = prev + 1, with prev < `FRAME_WIDTH-1`; or
  - col = 0 (start of any row).
  - The first pixel after reset must have col = 0.
  - A violation sets `err_order` at the next edge; it stays set until `rst`. The pixel is still processed.
- No backpressure: the block accepts `in_valid` every cycle.

## Timing
- Latency: `in_valid` sampled at edge E0 → `disp_valid`, `disp_out` and the feedback update are visible after edge E5 (5 cycles). Throughput is one pixel per cycle.
- `fb_ready` rises in the same cycle that `disp_valid` shows the last in-flight pixel. The issuer may sample the new `cost_aggr_last` / `min_aggr_last` and launch col+1 at the next edge.
- Reset (asynchronous, takes effect immediately, including mid-pipeline; all pipeline valid bits are cleared):
  - `cost_aggr_last` = all 0xFF; `min_aggr_last` = 0xFF.
  - `fb_row`, `fb_col`, `disp_out`, `disp_row`, `disp_col` = 0.
  - `disp_valid` = 0; `err_order` = 0; `fb_ready` = 1; counter = 0.
  - No `disp_valid` is produced for pixels that were in flight when reset was asserted.
- Pixel at the last column (`FRAME_WIDTH-1`): the feedback still updates. The next legal pixel is col 0, where the aggregator ignores the feedback.

## Test plan
- Single pixel: all costs 0x80 except d=37 = 0x03, `in_valid` at E0 → after E5 `disp_valid`=1 for one cycle, `disp_out`=57, `min_aggr_last`=0x03, `cost_aggr_last` equal to the input, `fb_ready` low from after E0 through E4 and high after E5.
- Tie: all costs 0x40 → `disp_out`=20, `min_aggr_last`=0x40. Then d=107 = 0x00, others 0x10 → `disp_out`=127, `min_aggr_last`=0x00.
- Back-to-back: row 2, cols 0–4 on consecutive edges E0–E4, each with a distinct minimum → `disp_valid` high after E5 through E9 with matching cols and disparities in order. `fb_ready` is low from after E0 until after E9, `fb_col`=4 at the end, `err_order`=0.
- Order error: row 1 col 3, then row 1 col 5 → `err_order`=1 from the following cycle and stays 1 through 20 further legal pixels. Both pixels still produce `disp_valid`.
- Row wrap: row 0 col 399, then row 1 col 0 → `err_order` stays 0. Row 1 col 0 followed by row 2 col 7 → `err_order`=1.
- Reset mid-flight: three pixels issued, `rst` pulsed asynchronously between edges E2 and E3 → outputs take reset values immediately, no `disp_valid` ever appears for those pixels, and `fb_ready`=1 after release.
